// File: rtl/uart_dma_rx.sv
// uart_dma_rx
// Receives 8N1 UART bytes and assembles them into DMA words. Each word carries
// a 7-bit destination address and an 18-bit data value, sent as four bytes:
//   byte0 = {1, addr[6:0]}, byte1 = dat[7:0], byte2 = dat[15:8],
//   byte3 = {6'b0, dat[17:16]}
// A byte with MSB 0 arriving at byte0 is dropped, so the receiver can find
// the start of the next word. If the line goes idle for too long in the
// middle of a word, the partial word is dropped.
//
// Optional feature, macro UART_DMA_RX_CHECKSUM_EN:
//   When defined, a fifth byte equal to the XOR of bytes 0-3 follows each
//   word. A word whose checksum does not match is dropped and frame_err is set.
//
// Parameters:
//   CLK_HZ       system clock frequency in Hz
//   BIT_RATE     UART bit rate (CLK_HZ/BIT_RATE must be at least 8)
//   TIMEOUT_BITS idle bit periods allowed between the bytes of one word
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   uart_rxd     UART receive pin, idle high, LSB first
//   dma_dat_r    received data word (18 bits)
//   dma_dat_addr received destination address (7 bits)
//   valid        dma_dat_r/dma_dat_addr hold a complete word
//   ready        consumer takes the word when valid & ready
//   busy         a word is partially received
//   frame_err    sticky: bad stop bit or malformed word
//   overrun      sticky: a complete word was dropped because valid was high
module uart_dma_rx #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  output logic [17:0] dma_dat_r,
  output logic [6:0]  dma_dat_addr,
  output logic        valid,
  input  logic        ready,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W         = $clog2(TO_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_sync1, r_sync2, r_syncPrev;
  logic [CNT_W-1:0]  r_clkCnt;
  logic [2:0]        r_bitCnt;
  logic [7:0]        r_shift;
  logic              w_tick;
  logic              w_stopOk, w_stopBad;
  logic [2:0]        r_byteIdx;
  logic [TO_W-1:0]   r_toCnt;
  logic [6:0]        r_addrAsm;
  logic [15:0]       r_datLo;
  logic              w_byte3Ok;
  logic              w_wordDone;
  logic [17:0]       w_wordDat;
  logic              r_frameErr;
  logic              r_valid;
  logic              r_overrun;
  logic [17:0]       r_datOut;
  logic [6:0]        r_addrOut;
`ifdef UART_DMA_RX_CHECKSUM_EN
  logic [1:0]        r_datHi;
  logic [7:0]        r_csum;
`endif

  // The pin is asynchronous, so it passes through two flops. A third flop
  // keeps the previous synchronized value so a falling edge can be detected.
  // All three reset high, which matches an idle line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_syncPrev <= 1'b1;
    end else begin
      r_sync1    <= uart_rxd;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
    end
  end

  // Bit FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic. w_tick marks the clock on which the line is sampled:
  // half a bit into the start bit, then one full bit period apart for each
  // data bit and for the stop bit.
  always_comb begin
    w_tick      = 1'b0;
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (r_syncPrev && !r_sync2) w_nextState = START;
      end
      START: begin
        w_tick = (r_clkCnt == CNT_W'(HALF_BIT - 1));
        if (w_tick) w_nextState = r_sync2 ? IDLE : DATA;
      end
      DATA: begin
        w_tick = (r_clkCnt == CNT_W'(CLKS_PER_BIT - 1));
        if (w_tick && r_bitCnt == 3'd7) w_nextState = STOP;
      end
      STOP: begin
        w_tick = (r_clkCnt == CNT_W'(CLKS_PER_BIT - 1));
        if (w_tick) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_stopOk  = (r_state == STOP) && w_tick && r_sync2;
  assign w_stopBad = (r_state == STOP) && w_tick && !r_sync2;

  // Bit timing and data capture. The clock counter restarts on every sample
  // and stays at zero in IDLE, so each START begins counting from zero.
  // Data bits shift in from the top, so after eight samples the byte is
  // in LSB-first order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clkCnt <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
    end else begin
      if (r_state == IDLE || w_tick) r_clkCnt <= '0;
      else                           r_clkCnt <= r_clkCnt + 1'b1;
      if (r_state == DATA && w_tick) begin
        r_shift  <= {r_sync2, r_shift[7:1]};
        r_bitCnt <= r_bitCnt + 1'b1;
      end else if (r_state == IDLE) begin
        r_bitCnt <= '0;
      end
    end
  end

  assign w_byte3Ok = (r_shift[7:2] == 6'b0);

`ifdef UART_DMA_RX_CHECKSUM_EN
  assign w_wordDone = w_stopOk && (r_byteIdx == 3'd4) && (r_shift == r_csum);
  assign w_wordDat  = {r_datHi, r_datLo};
`else
  assign w_wordDone = w_stopOk && (r_byteIdx == 3'd3) && w_byte3Ok;
  assign w_wordDat  = {r_shift[1:0], r_datLo};
`endif

  // Word assembly. Each good byte is stored according to its position in the
  // word. A bad stop bit, a malformed byte3 or a checksum mismatch resets the
  // position to byte0 and sets the sticky frame error. The idle timeout only
  // counts between bytes of a partial word and drops that word silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byteIdx  <= '0;
      r_toCnt    <= '0;
      r_addrAsm  <= '0;
      r_datLo    <= '0;
      r_frameErr <= 1'b0;
`ifdef UART_DMA_RX_CHECKSUM_EN
      r_datHi    <= '0;
      r_csum     <= '0;
`endif
    end else if (w_stopBad) begin
      r_byteIdx  <= '0;
      r_toCnt    <= '0;
      r_frameErr <= 1'b1;
    end else if (w_stopOk) begin
      r_toCnt <= '0;
      case (r_byteIdx)
        3'd0: begin
          if (r_shift[7]) begin
            r_addrAsm <= r_shift[6:0];
            r_byteIdx <= 3'd1;
`ifdef UART_DMA_RX_CHECKSUM_EN
            r_csum    <= r_shift;
`endif
          end
        end
        3'd1: begin
          r_datLo[7:0] <= r_shift;
          r_byteIdx    <= 3'd2;
`ifdef UART_DMA_RX_CHECKSUM_EN
          r_csum       <= r_csum ^ r_shift;
`endif
        end
        3'd2: begin
          r_datLo[15:8] <= r_shift;
          r_byteIdx     <= 3'd3;
`ifdef UART_DMA_RX_CHECKSUM_EN
          r_csum        <= r_csum ^ r_shift;
`endif
        end
        3'd3: begin
          if (!w_byte3Ok) begin
            r_frameErr <= 1'b1;
            r_byteIdx  <= 3'd0;
          end else begin
`ifdef UART_DMA_RX_CHECKSUM_EN
            r_datHi   <= r_shift[1:0];
            r_csum    <= r_csum ^ r_shift;
            r_byteIdx <= 3'd4;
`else
            r_byteIdx <= 3'd0;
`endif
          end
        end
        default: begin
`ifdef UART_DMA_RX_CHECKSUM_EN
          if (r_shift != r_csum) r_frameErr <= 1'b1;
`endif
          r_byteIdx <= 3'd0;
        end
      endcase
    end else if (r_state == IDLE && r_byteIdx != 3'd0) begin
      if (r_toCnt == TO_W'(TO_LIMIT - 1)) begin
        r_byteIdx <= '0;
        r_toCnt   <= '0;
      end else begin
        r_toCnt <= r_toCnt + 1'b1;
      end
    end else if (r_byteIdx == 3'd0) begin
      r_toCnt <= '0;
    end
  end

  // Output holding register and handshake. A finished word loads when the
  // register is empty or is being emptied on this same clock. Otherwise the
  // new word is dropped and the held word stays untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_datOut  <= '0;
      r_addrOut <= '0;
    end else if (w_wordDone) begin
      if (!r_valid || ready) begin
        r_datOut  <= w_wordDat;
        r_addrOut <= r_addrAsm;
        r_valid   <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign dma_dat_r    = r_datOut;
  assign dma_dat_addr = r_addrOut;
  assign valid        = r_valid;
  assign busy         = (r_byteIdx != 3'd0);
  assign frame_err    = r_frameErr;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_uart_dma_rx.sv
// tb_uart_dma_rx
// Testbench for uart_dma_rx, using CLK_HZ=1 MHz and BIT_RATE=100 kbit/s
// (10 clocks per bit). A reference model in this bench follows the word-format
// rules byte by byte and queues the words the receiver should deliver. A
// monitor pops that queue on every valid&ready handshake and compares.
// Compile with UART_DMA_RX_CHECKSUM_EN defined to test the checksum build.
`timescale 1ns/1ps
module tb_uart_dma_rx;

  localparam int CPB     = 10;
  localparam int TO_CLKS = 20 * CPB;
`ifdef UART_DMA_RX_CHECKSUM_EN
  localparam int WORD_BYTES = 5;
`else
  localparam int WORD_BYTES = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_rxd;
  logic        ready;
  logic [17:0] dma_dat_r;
  logic [6:0]  dma_dat_addr;
  logic        valid;
  logic        busy;
  logic        frame_err;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  logic [24:0] expQ[$];
  logic [7:0]  mBytes[$];
  bit          mFrameErr;
  bit          mOverrun;
  bit          mHolding;

  uart_dma_rx #(
    .CLK_HZ(1000000),
    .BIT_RATE(100000),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_rxd(uart_rxd),
    .dma_dat_r(dma_dat_r),
    .dma_dat_addr(dma_dat_addr),
    .valid(valid),
    .ready(ready),
    .busy(busy),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  // 100 MHz simulation clock; only the cycle count matters to the design.
  always #5 clk = ~clk;

  // Stop the run if it gets stuck anywhere.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: compare every word the consumer takes with the oldest
  // predicted word.
  always @(negedge clk) begin
    logic [24:0] e;
    if (!reset && valid && ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_word: actual addr=%0d dat=%0d required=none",
                 dma_dat_addr, dma_dat_r);
      end else begin
        e = expQ.pop_front();
        if ({dma_dat_addr, dma_dat_r} !== e) begin
          errors++;
          $display("[TB] FAIL word: actual addr=%0d dat=%0d required addr=%0d dat=%0d",
                   dma_dat_addr, dma_dat_r, e[24:18], e[17:0]);
        end
      end
    end
  end

  // Compare one value with what the bench expects.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: a finished word goes out unless an earlier word is still waiting
  // for the consumer.
  task automatic modelDeliver(input logic [6:0] a, input logic [17:0] d);
    if (ready) expQ.push_back({a, d});
    else if (mHolding) mOverrun = 1'b1;
    else begin
      expQ.push_back({a, d});
      mHolding = 1'b1;
    end
  endtask

  // Model: process one received byte using the word-format rules.
  task automatic modelByte(input logic [7:0] b, input bit stopOk);
    logic [7:0] b0, b1, b2, b3, b4;
    if (!stopOk) begin
      mBytes.delete();
      mFrameErr = 1'b1;
      return;
    end
    if (mBytes.size() == 0 && !b[7]) return;
    mBytes.push_back(b);
    if (mBytes.size() == 4) begin
      b3 = mBytes[3];
      if (b3[7:2] != 6'b0) begin
        mFrameErr = 1'b1;
        mBytes.delete();
        return;
      end
    end
    if (mBytes.size() == WORD_BYTES) begin
      b0 = mBytes[0]; b1 = mBytes[1]; b2 = mBytes[2]; b3 = mBytes[3];
      b4 = (WORD_BYTES == 5) ? mBytes[WORD_BYTES-1] : (b0 ^ b1 ^ b2 ^ b3);
      if (b4 != (b0 ^ b1 ^ b2 ^ b3)) mFrameErr = 1'b1;
      else modelDeliver(b0[6:0], {b3[1:0], b2, b1});
      mBytes.delete();
    end
  endtask

  task automatic driveBit(input logic v);
    uart_rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Send one UART byte; stopOk=0 sends a low stop bit, then lets the line
  // return to idle.
  task automatic applyStimulus(input logic [7:0] b, input bit stopOk);
    modelByte(b, stopOk);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(stopOk);
    if (!stopOk) driveBit(1'b1);
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    if (n >= TO_CLKS) mBytes.delete();
  endtask

  // Send a full word; badB3 corrupts byte3, badCs corrupts the checksum byte.
  task automatic sendWordX(input logic [6:0] a, input logic [17:0] d, input int gap,
                           input bit badB3, input bit badCs);
    logic [7:0] bs[5];
    bs[0] = {1'b1, a};
    bs[1] = d[7:0];
    bs[2] = d[15:8];
    bs[3] = {6'b0, d[17:16]};
    if (badB3) bs[3][7:2] = 6'($urandom_range(1, 63));
    bs[4] = bs[0] ^ bs[1] ^ bs[2] ^ bs[3];
    if (badCs) bs[4] = bs[4] ^ 8'($urandom_range(1, 255));
    for (int i = 0; i < WORD_BYTES; i++) applyStimulus(bs[i], 1'b1);
    idle(gap);
  endtask

  task automatic sendWord(input logic [6:0] a, input logic [17:0] d, input int gap);
    sendWordX(a, d, gap, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && expQ.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0]  ra;
    logic [17:0] rd;
    int          kind;
    int          gap;

    reset = 1'b1; uart_rxd = 1'b1; ready = 1'b1;
    mFrameErr = 0; mOverrun = 0; mHolding = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_dat", dma_dat_r, 0);
    checkOutput("rst_addr", dma_dat_addr, 0);
    reset = 1'b0;
    idle(5);

    $display("[TB] basic word");
    sendWord(7'd120, 18'd34133, 20);
    drain();
    checkOutput("basic_drained", expQ.size(), 0);
    checkOutput("basic_valid", valid, 0);
    checkOutput("basic_frame_err", frame_err, 0);
    checkOutput("basic_overrun", overrun, 0);

    $display("[TB] overrun");
    ready = 1'b0;
    sendWord(7'd120, 18'd34133, 20);
    sendWord(7'd5, 18'd1, 20);
    checkOutput("ovr_valid_held", valid, 1);
    checkOutput("ovr_addr_held", dma_dat_addr, 120);
    checkOutput("ovr_dat_held", dma_dat_r, 34133);
    checkOutput("ovr_flag", overrun, 32'(mOverrun));
    ready = 1'b1;
    mHolding = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ovr_consumed_valid", valid, 0);
    checkOutput("ovr_drained", expQ.size(), 0);
    checkOutput("ovr_sticky", overrun, 1);

    $display("[TB] resync");
    applyStimulus(8'h55, 1'b1);
    idle(20);
    sendWord(7'd120, 18'd34133, 20);
    drain();
    checkOutput("resync_drained", expQ.size(), 0);
    checkOutput("resync_frame_err", frame_err, 32'(mFrameErr));

    $display("[TB] timeout");
    applyStimulus(8'hF8, 1'b1);
    applyStimulus(8'h55, 1'b1);
    checkOutput("to_busy_partial", busy, 1);
    idle(250);
    checkOutput("to_busy_dropped", busy, 0);
    sendWord(7'd3, 18'h2ABCD, 20);
    drain();
    checkOutput("to_drained", expQ.size(), 0);
    checkOutput("to_frame_err", frame_err, 0);

`ifdef UART_DMA_RX_CHECKSUM_EN
    $display("[TB] bad checksum");
    applyStimulus(8'hF8, 1'b1);
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'h85, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h29, 1'b1);
    idle(20);
    checkOutput("cs_frame_err", frame_err, 32'(mFrameErr));
    checkOutput("cs_valid", valid, 0);
    checkOutput("cs_busy", busy, 0);
`endif

    $display("[TB] bad stop bit and reset mid-byte");
    applyStimulus(8'hF8, 1'b0);
    idle(20);
    checkOutput("stop_frame_err", frame_err, 1);
    checkOutput("stop_valid", valid, 0);
    checkOutput("stop_busy", busy, 0);
    applyStimulus(8'hF8, 1'b1);
    uart_rxd = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_frame_err", frame_err, 0);
    checkOutput("mid_rst_overrun", overrun, 0);
    checkOutput("mid_rst_dat", dma_dat_r, 0);
    checkOutput("mid_rst_addr", dma_dat_addr, 0);
    uart_rxd = 1'b1;
    mBytes.delete();
    mFrameErr = 0; mOverrun = 0; mHolding = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5);
    sendWord(7'd5, 18'd1, 20);
    drain();
    checkOutput("post_rst_drained", expQ.size(), 0);

    $display("[TB] random words");
    for (int n = 0; n < 25; n++) begin
      ra   = 7'($urandom_range(0, 127));
      rd   = 18'($urandom);
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(0, 40);
      if (kind == 0) begin
        applyStimulus({1'b0, 7'($urandom)}, 1'b1);
        idle(gap);
        sendWord(ra, rd, gap);
      end else if (kind == 1) begin
        sendWordX(ra, rd, gap, 1'b1, 1'b0);
        idle(250);
      end else if (kind == 2) begin
        sendWordX(ra, rd, gap, 1'b0, 1'b1);
        idle(250);
      end else begin
        sendWord(ra, rd, gap);
      end
    end
    idle(30);
    drain();
    checkOutput("rand_drained", expQ.size(), 0);
    checkOutput("rand_frame_err", frame_err, 32'(mFrameErr));
    checkOutput("rand_overrun", overrun, 32'(mOverrun));
    checkOutput("rand_busy", busy, 32'(mBytes.size() != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_dma_rx.md
UART_DMA_RX -- requirements
Module: uart_dma_rx

Interface
REQ-001 CLK_HZ, 50000000, system clock frequency in Hz.
REQ-002 BIT_RATE, 9600, UART bit rate; CLKS_PER_BIT = CLK_HZ/BIT_RATE (integer division), at least 8.
REQ-003 TIMEOUT_BITS, 20, idle bit periods allowed between bytes of one word before the partial word is dropped.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 uart_rxd  input  1  UART receive pin: 8N1, idle high, LSB first.
REQ-007 dma_dat_r  output  18  received cherry_float word.
REQ-008 dma_dat_addr  output  7  received destination address.
REQ-009 valid  output  1  dma_dat_r/dma_dat_addr hold a complete word.
REQ-010 ready  input  1  consumer accepts the word when valid&ready.
REQ-011 busy  output  1  a word is partially received (at least 1 byte and fewer than all bytes).
REQ-012 frame_err  output  1  sticky: bad stop bit or malformed word since reset.
REQ-013 overrun  output  1  sticky: a complete word was dropped because valid was still high.

Function
REQ-014 uart_rxd shall pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-015 Bit FSM states: IDLE, START, DATA, STOP; IDLE->START on a synchronized high-to-low transition.
REQ-016 START: wait CLKS_PER_BIT/2 clocks, resample; low -> DATA, high -> IDLE (false start, no flag).
REQ-017 DATA: sample 8 bits, one every CLKS_PER_BIT clocks, shifted in LSB first; then -> STOP.
REQ-018 STOP: sample after CLKS_PER_BIT clocks; high -> byte accepted; low -> byte discarded, frame_err set, word assembly reset to byte 0; -> IDLE in both cases.
REQ-019 Word format: byte0 = {1, addr[6:0]}; byte1 = dat[7:0]; byte2 = dat[15:8]; byte3 = {6'b0, dat[17:16]}.
REQ-020 At byte index 0, a byte with MSB 0 shall be silently discarded (resync) and the index shall stay 0.
REQ-021 byte3 with any of bits[7:2] nonzero: word discarded, frame_err set, index reset to 0.
REQ-022 Word-complete: if valid is low, load dma_dat_r/dma_dat_addr and raise valid on the next clock; if valid is high, drop the word and set overrun; the held word stays unchanged in that case.
REQ-023 valid shall clear the cycle after valid&ready; valid shall not clear otherwise.
REQ-024 Simultaneous word-complete and valid&ready in the same cycle: the new word is loaded, valid stays 1, and overrun is not set.
REQ-025 Timeout counter: cleared on each accepted byte; counts while the bit FSM is in IDLE and the byte index is nonzero; at TIMEOUT_BITS*CLKS_PER_BIT the index resets to 0, with no flag.
REQ-026 busy = (byte index != 0).
REQ-027 Latency: valid rises 1 clock after the final stop-bit sample.

Reset
REQ-028 On reset: FSM in IDLE, byte index 0, all counters 0, synchronizer 1.
REQ-029 On reset: dma_dat_r 0, dma_dat_addr 0, valid 0, busy 0, frame_err 0, overrun 0.
REQ-030 Reset asserted mid-byte or mid-word shall discard all partial data; the next word is received normally after reset deasserts.

Configuration
REQ-031 Macro UART_DMA_RX_CHECKSUM_EN.
- Defined: a 5th byte equal to the XOR of bytes 0-3 is appended to each word.
- Mismatch: word discarded, frame_err set, index reset to 0.
- Undefined: 4-byte words; no checksum logic is built.

Verification
REQ-032 All scenarios use CLK_HZ=1000000 and BIT_RATE=100000, giving CLKS_PER_BIT=10.
REQ-033 Send bytes F8,55,85,00 (plus 28 if checksum enabled), ready=1 -> one valid pulse with dma_dat_addr=120 and dma_dat_r=34133; frame_err=0 and overrun=0.
REQ-034 Hold ready=0 and send two words (addr 120/34133, then addr 5/1) -> the first word is held, overrun=1; after ready=1, the first word is consumed and valid=0.
REQ-035 Send byte 55, then the F8,55,85,00 word -> the leading 55 is ignored, the word is received correctly, frame_err=0.
REQ-036 Send F8,55 then idle 250 clocks, then a full word for addr 3 -> busy drops at timeout; only the addr-3 word is output.
REQ-037 Send byte F8 with stop bit low -> frame_err=1, no valid; assert reset mid-byte afterwards -> all outputs return to reset values.
REQ-038 With checksum enabled, send F8,55,85,00,29 -> no valid, frame_err=1.
